cache_refill_ctrl: RTL and testbench

- Sequencing controller in front of the direct-mapped cache (16-byte lines, 32-bit words, tag+valid table).
- Accepts one CPU load/store at a time and performs the tag lookup.
- On a read miss it fetches the 4-word line from main memory, writes it into cache storage, then writes the tag/valid entry and replays the lookup.
- Stores are write-through: the cache is updated on hit only, and main memory is always written.

---
 rtl/cache_pkg.sv | 11 +
 rtl/sat_counter.sv | 11 +
 rtl/cache_refill_ctrl.sv | 100 ++++++++++
 tb/tb_cache_refill_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and cache line geometry for the refill controller.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, FILL_WR, TAG_UPD, MEM_WR, DONE} state_t;
  localparam int LINE_BYTES = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_LSB = OFFSET_W;
  localparam int INDEX_MSB = 17;
  localparam int TAG_LSB = INDEX_MSB + 1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge CLR)
    if (CLR) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: serialises CPU loads/stores against a direct-mapped cache,
// refilling 4-word lines on read misses and writing stores through to memory.
module cache_refill_ctrl import cache_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_we,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  state_t state, nxt;
  logic [ADDR_W-3:0] addr_q;
  logic we_q, replay;
  logic [DATA_W-1:0] wdata_q;
  logic [WORD_IDX_W-1:0] k;
  logic last_word, hit_inc, miss_inc, unused_ok;
  assign unused_ok = ^cpu_addr[1:0];
  assign lk_addr = {addr_q, 2'b00};
  assign fill_addr = {addr_q[ADDR_W-3:OFFSET_W-2], k, 2'b00};
  assign last_word = k == WORD_IDX_W'(WORDS_PER_LINE - 1);
  always_ff @(posedge clk or posedge CLR)
    if (CLR) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cpu_req ? LOOKUP : IDLE;
      LOOKUP:  nxt = we_q ? MEM_WR : cache_hit ? DONE : REFILL;
      REFILL:  nxt = mem_ack ? FILL_WR : REFILL;
      FILL_WR: nxt = last_word ? TAG_UPD : REFILL;
      TAG_UPD: nxt = LOOKUP;
      MEM_WR:  nxt = mem_ack ? DONE : MEM_WR;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE;
    cpu_ready = state == DONE;
    cache_we  = state == LOOKUP && we_q && cache_hit;
    fill_we   = state == FILL_WR;
    tag_we    = state == TAG_UPD;
    mem_req   = state == REFILL || state == MEM_WR;
    mem_we    = state == MEM_WR;
    mem_addr  = state == REFILL ? fill_addr : state == MEM_WR ? lk_addr : '0;
    mem_wdata = state == MEM_WR ? wdata_q : '0;
    hit_inc   = state == LOOKUP && cache_hit && (we_q || !replay);
    miss_inc  = state == LOOKUP && !we_q && !cache_hit;
  end
  // replay marks the post-refill lookup so it is not double-counted as a hit
  always_ff @(posedge clk or posedge CLR)
    if (CLR) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      k         <= '0;
      replay    <= 1'b0;
      cpu_rdata <= '0;
      fill_data <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        addr_q  <= cpu_addr[ADDR_W-1:2];
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (state == LOOKUP && !we_q && cache_hit) begin
        cpu_rdata <= cache_rdata;
        replay    <= 1'b0;
      end
      if (miss_inc) k <= '0;
      if (state == REFILL && mem_ack) fill_data <= mem_rdata;
      if (state == FILL_WR && !last_word) k <= k + 1'b1;
      if (state == TAG_UPD) replay <= 1'b1;
    end
  sat_counter #(.CNT_W(CNT_W)) u_hit  (.clk(clk), .CLR(CLR), .inc(hit_inc),  .cnt(hit_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_miss (.clk(clk), .CLR(CLR), .inc(miss_inc), .cnt(miss_cnt));
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed checks of hit, miss refill, write-through, back-pressure,
// reset mid-refill and counter saturation (on a narrow-counter second instance).
module tb_cache_refill_ctrl;
  logic clk = 0, CLR = 0;
  logic cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic mem_ack = 0;
  logic [31:0] mem_rdata = 0;
  logic force_hit = 0;
  logic [31:0] force_data = 0;
  logic [31:0] cpu_rdata, lk_addr, fill_addr, fill_data, mem_addr, mem_wdata, cache_rdata;
  logic cpu_ready, busy, cache_we, fill_we, tag_we, mem_req, mem_we, cache_hit;
  logic [15:0] hit_cnt, miss_cnt;
  logic [31:0] s_rdata, s_lk, s_faddr, s_fdata, s_maddr, s_mwdata;
  logic s_ready, s_busy, s_cwe, s_fwe, s_twe, s_mreq, s_mwe;
  logic [3:0] s_hit, s_miss;
  int errors = 0, checks = 0;
  int mem_wait = 0, wcnt = 0;
  int reqcyc = 0, unstable = 0, fills = 0, fill_bad = 0, tags = 0, cwe = 0, writes = 0;
  logic [31:0] last_wa = 0, last_wd = 0, prev_addr = 0;
  logic prev_req = 0;
  logic [31:0] rd_q[$];
  int lat;
  logic [31:0] rd;
  bit vld [64];
  bit [27:0] tagm [64];
  bit [31:0] dm [256];

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .CLR(CLR), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
    .lk_addr(lk_addr), .cache_hit(cache_hit), .cache_rdata(cache_rdata), .cache_we(cache_we),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data), .tag_we(tag_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  cache_refill_ctrl #(.CNT_W(4)) u_s (
    .clk(clk), .CLR(CLR), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(s_rdata), .cpu_ready(s_ready), .busy(s_busy),
    .lk_addr(s_lk), .cache_hit(cache_hit), .cache_rdata(cache_rdata), .cache_we(s_cwe),
    .fill_we(s_fwe), .fill_addr(s_faddr), .fill_data(s_fdata), .tag_we(s_twe),
    .mem_req(s_mreq), .mem_we(s_mwe), .mem_addr(s_maddr), .mem_wdata(s_mwdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(s_hit), .miss_cnt(s_miss));

  // cache storage model: tag/valid table and data words, indexed by a few low index bits
  assign cache_hit = force_hit | (vld[lk_addr[9:4]] && tagm[lk_addr[9:4]] == lk_addr[31:4]);
  assign cache_rdata = force_hit ? force_data : dm[lk_addr[9:2]];
  always @(posedge clk) begin
    if (tag_we) begin
      vld[lk_addr[9:4]] <= 1'b1;
      tagm[lk_addr[9:4]] <= lk_addr[31:4];
    end
    if (fill_we) dm[fill_addr[9:2]] <= fill_data;
    if (cache_we) dm[lk_addr[9:2]] <= cpu_wdata;
  end

  // memory: acks after mem_wait idle cycles, read data is 0xA0 + word index
  initial forever begin
    @(negedge clk);
    if (mem_req && wcnt == mem_wait) begin
      mem_ack = 1;
      mem_rdata = 32'hA0 + {30'b0, mem_addr[3:2]};
      wcnt = 0;
    end else begin
      mem_ack = 0;
      wcnt = mem_req ? wcnt + 1 : 0;
    end
  end

  // bus monitor
  initial forever begin
    @(negedge clk);
    if (mem_req) reqcyc++;
    if (mem_req && prev_req && mem_addr != prev_addr) unstable++;
    if (mem_req && !prev_req && !mem_we) rd_q.push_back(mem_addr);
    if (mem_req && !prev_req && mem_we) begin
      writes++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
    if (fill_we) begin
      fills++;
      if (fill_data != 32'hA0 + {30'b0, fill_addr[3:2]}) fill_bad++;
    end
    if (tag_we) tags++;
    if (cache_we) cwe++;
    prev_req = mem_req;
    prev_addr = mem_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d, input int w, input bit pulse);
    mem_wait = w;
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_req = 0;
    lat = 1;
    while (!cpu_ready && lat < 400) begin
      @(negedge clk);
      lat++;
      cpu_req = pulse && (lat == 5 || lat == 10 || lat == 20);
    end
    cpu_req = 0;
    rd = cpu_rdata;
    chk("ready_timeout", cpu_ready, 1);
  endtask

  function automatic logic any_out();
    return |{cpu_rdata, cpu_ready, busy, lk_addr, cache_we, fill_we, fill_addr, fill_data,
             tag_we, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt};
  endfunction

  initial begin
    int f0, t0, c0, w0, r0, n;
    #1 CLR = 1;
    #2 chk("reset_outputs", any_out(), 0);
    @(negedge clk); @(negedge clk);
    CLR = 0;

    // read miss with zero-wait memory
    f0 = fills; t0 = tags;
    op(0, 32'h0004_0024, 0, 0, 0);
    chk("miss_latency", lat, 12);
    chk("miss_rdata", rd, 32'hA1);
    chk("miss_addr0", rd_q[0], 32'h0004_0020);
    chk("miss_addr1", rd_q[1], 32'h0004_0024);
    chk("miss_addr2", rd_q[2], 32'h0004_0028);
    chk("miss_addr3", rd_q[3], 32'h0004_002C);
    chk("miss_fills", fills - f0, 4);
    chk("miss_fill_data_bad", fill_bad, 0);
    chk("miss_tag_we", tags - t0, 1);
    chk("miss_cnt_1", miss_cnt, 1);
    chk("hit_cnt_0", hit_cnt, 0);

    // read hit
    force_hit = 1; force_data = 32'h1; r0 = reqcyc;
    op(0, 32'h0000_0010, 0, 0, 0);
    chk("hit_latency", lat, 2);
    chk("hit_rdata", rd, 32'h1);
    chk("hit_cnt_1", hit_cnt, 1);
    chk("hit_no_mem_req", reqcyc - r0, 0);

    // store hit: write-through plus cache update
    c0 = cwe; w0 = writes;
    op(1, 32'h0000_0030, 32'hDEAD_BEEF, 0, 0);
    chk("st_hit_latency", lat, 3);
    chk("st_hit_cache_we", cwe - c0, 1);
    chk("st_hit_mem_write", writes - w0, 1);
    chk("st_hit_mem_addr", last_wa, 32'h0000_0030);
    chk("st_hit_mem_data", last_wd, 32'hDEAD_BEEF);
    chk("st_hit_cnt", hit_cnt, 2);

    // store miss: no allocation
    force_hit = 0; c0 = cwe; w0 = writes; f0 = fills;
    op(1, 32'h0000_0030, 32'hDEAD_BEEF, 0, 0);
    chk("st_miss_latency", lat, 3);
    chk("st_miss_cache_we", cwe - c0, 0);
    chk("st_miss_no_refill", fills - f0, 0);
    chk("st_miss_mem_write", writes - w0, 1);
    chk("st_miss_counts", {hit_cnt, miss_cnt}, {16'd2, 16'd1});

    // back-pressure with ignored cpu_req pulses
    r0 = reqcyc;
    op(0, 32'h0000_0108, 0, 5, 1);
    chk("bp_latency", lat, 32);
    chk("bp_rdata", rd, 32'hA2);
    chk("bp_req_cycles", reqcyc - r0, 24);
    chk("bp_addr_stable", unstable, 0);
    @(negedge clk);
    chk("bp_idle_after_done", busy, 0);
    chk("bp_miss_cnt", miss_cnt, 2);

    // reset in the middle of a refill
    mem_wait = 0; t0 = tags; n = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0200;
    @(negedge clk);
    cpu_req = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(negedge clk);
      if (fill_we) n++;
    end
    chk("rst_mid_two_fills", n, 2);
    @(negedge clk);
    CLR = 1;
    #1 chk("rst_mid_outputs", any_out(), 0);
    @(negedge clk);
    CLR = 0;
    chk("rst_mid_no_tag", tags - t0, 0);
    op(0, 32'h0000_0200, 0, 0, 0);
    chk("rst_reload_latency", lat, 12);
    chk("rst_reload_rdata", rd, 32'hA0);
    chk("rst_reload_miss", miss_cnt, 1);
    chk("rst_reload_hit", hit_cnt, 0);

    // saturation on the 4-bit counter instance
    force_hit = 1; force_data = 32'h5;
    for (int i = 0; i < 17; i++) op(0, 32'h0000_0010, 0, 0, 0);
    chk("sat_wide_hit", hit_cnt, 17);
    chk("sat_narrow_hit", s_hit, 4'hF);
    chk("sat_narrow_miss", s_miss, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
